ikaopll_pg_tdm: RTL and testbench

//  Parametrised time-division-multiplexed phase generator for NUM_CH channels x 2 operators (modulator/carrier).

---
 rtl/ikaopll_pg_tdm.sv | 116 +++++++++++
 tb/tb_ikaopll_pg_tdm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_pg_tdm.sv
// Time-division-multiplexed phase generator: 2*NUM_CH operator slots, two-stage
// delta/accumulate pipeline with internal vibrato counter and slot-tagged output.
module ikaopll_pg_tdm #(
  parameter int unsigned NUM_CH       = 9,
  parameter int unsigned FNUM_W       = 9,
  parameter int unsigned PHASE_W      = 19,
  parameter int unsigned OUT_W        = 10,
  parameter int unsigned VIB_DIV_LOG2 = 10,
  localparam int unsigned SLOT_W      = $clog2(2 * NUM_CH)
) (
  input  logic              i_EMUCLK,
  input  logic              i_MRST,
  input  logic              i_phi1_PCEN_n,
  input  logic [FNUM_W-1:0] i_FNUM,
  input  logic [2:0]        i_BLOCK,
  input  logic [3:0]        i_MUL,
  input  logic              i_PM_EN,
  input  logic              i_PG_PHASE_RST,
  output logic [SLOT_W-1:0] o_SLOT,
  output logic              o_FRAME_START,
  output logic [4:0]        o_EG_PDELTA_SHIFT_AMOUNT,
  output logic [OUT_W-1:0]  o_OP_PHASEDATA,
  output logic [SLOT_W-1:0] o_OUT_SLOT,
  output logic              o_PHASE_VALID
);

  localparam int unsigned NUM_SLOT = 2 * NUM_CH;
  localparam int unsigned F_W      = FNUM_W + 2;
  localparam int unsigned D_W      = F_W + 6;
  localparam int unsigned P_W      = D_W + 5;

  logic [VIB_DIV_LOG2-1:0] frame_cnt;
  logic [2:0]              vib_cnt;
  logic [PHASE_W-1:0]      phase [NUM_SLOT];

  logic                    s1_valid;
  logic [SLOT_W-1:0]       s1_slot;
  logic                    s1_rst;
  logic [3:0]              s1_mul;
  logic [D_W-1:0]          s1_dblk;

  logic                    last_slot;
  logic [1:0]              vib_mag;
  logic [F_W-1:0]          pm_mag;
  logic [F_W-1:0]          f_adj;
  logic [D_W:0]            d_shl;
  logic [D_W-1:0]          d_blk;
  logic [4:0]              m2;
  logic [P_W-1:0]          prod;
  logic [PHASE_W-1:0]      new_phase;

  // Stage 1: vibrato offset (table 0,1,2,1,0,-1,-2,-1 as magnitude + sign) and octave shift
  always_comb begin
    last_slot = (o_SLOT == SLOT_W'(NUM_SLOT - 1));
    vib_mag   = vib_cnt[0] ? 2'd1 : (vib_cnt[1] ? 2'd2 : 2'd0);
    pm_mag    = i_PM_EN ? F_W'(i_FNUM[FNUM_W-1 -: 3]) * F_W'(vib_mag) : '0;
    f_adj     = vib_cnt[2] ? F_W'(i_FNUM) - pm_mag : F_W'(i_FNUM) + pm_mag;
    d_shl     = (D_W + 1)'(f_adj) << i_BLOCK;
    d_blk     = D_W'(d_shl >> 1);
  end

  // Stage 2: multiplier table (2x the nominal MUL ratio) and accumulate
  always_comb begin
    m2 = 5'd0;
    case (s1_mul)
      4'd0:          m2 = 5'd1;
      4'd11:         m2 = 5'd20;
      4'd13:         m2 = 5'd24;
      4'd14, 4'd15:  m2 = 5'd30;
      default:       m2 = {s1_mul, 1'b0};
    endcase
    prod      = P_W'(s1_dblk) * P_W'(m2);
    new_phase = s1_rst ? '0 : phase[s1_slot] + PHASE_W'(prod >> 1);
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      o_SLOT                   <= '0;
      o_FRAME_START            <= 1'b1;
      o_EG_PDELTA_SHIFT_AMOUNT <= '0;
      o_OP_PHASEDATA           <= '0;
      o_OUT_SLOT               <= '0;
      o_PHASE_VALID            <= 1'b0;
      frame_cnt                <= '0;
      vib_cnt                  <= '0;
      s1_valid                 <= 1'b0;
      s1_slot                  <= '0;
      s1_rst                   <= 1'b0;
      s1_mul                   <= '0;
      s1_dblk                  <= '0;
      for (int i = 0; i < int'(NUM_SLOT); i++) phase[i] <= '0;
    end else if (!i_phi1_PCEN_n) begin
      o_SLOT        <= last_slot ? '0 : o_SLOT + SLOT_W'(1);
      o_FRAME_START <= last_slot;
      if (last_slot) begin
        frame_cnt <= frame_cnt + VIB_DIV_LOG2'(1);
        if (&frame_cnt) vib_cnt <= vib_cnt + 3'd1;
      end

      o_EG_PDELTA_SHIFT_AMOUNT <= {i_BLOCK, i_FNUM[FNUM_W-1 -: 2]};
      s1_valid <= 1'b1;
      s1_slot  <= o_SLOT;
      s1_rst   <= i_PG_PHASE_RST;
      s1_mul   <= i_MUL;
      s1_dblk  <= d_blk;

      if (s1_valid) begin
        phase[s1_slot] <= new_phase;
        o_OP_PHASEDATA <= new_phase[PHASE_W-1 -: OUT_W];
        o_OUT_SLOT     <= s1_slot;
        o_PHASE_VALID  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ikaopll_pg_tdm.sv
// Bench for ikaopll_pg_tdm: per-cycle scoreboard against a behavioural model,
// plus table-driven frame checks and hand-written reset/vibrato/phase-reset sequences.
module tb_ikaopll_pg_tdm;

  localparam int NS = 18;

  logic       clk = 1'b0;
  logic       mrst = 1'b0;
  logic       pcen_n = 1'b1;
  logic [8:0] fnum = '0;
  logic [2:0] blk = '0;
  logic [3:0] mul = '0;
  logic       pm_en = 1'b0;
  logic       prst = 1'b0;
  logic [4:0] slot;
  logic       frame_start;
  logic [4:0] eg_shift;
  logic [9:0] phdata;
  logic [4:0] out_slot;
  logic       valid;

  always #5 clk = ~clk;

  ikaopll_pg_tdm #(
    .NUM_CH(9), .FNUM_W(9), .PHASE_W(19), .OUT_W(10), .VIB_DIV_LOG2(1)
  ) dut (
    .i_EMUCLK                (clk),
    .i_MRST                  (mrst),
    .i_phi1_PCEN_n           (pcen_n),
    .i_FNUM                  (fnum),
    .i_BLOCK                 (blk),
    .i_MUL                   (mul),
    .i_PM_EN                 (pm_en),
    .i_PG_PHASE_RST          (prst),
    .o_SLOT                  (slot),
    .o_FRAME_START           (frame_start),
    .o_EG_PDELTA_SHIFT_AMOUNT(eg_shift),
    .o_OP_PHASEDATA          (phdata),
    .o_OUT_SLOT              (out_slot),
    .o_PHASE_VALID           (valid)
  );

  typedef struct { int due; int slot; int data; } exp_t;
  typedef struct { int fnum; int blk; int mul; int nf; int exp; } vec_t;

  int     n_vec = 0;
  int     n_err = 0;
  exp_t   q_ph[$];
  exp_t   q_sh[$];
  exp_t   cur_ph;
  int     cur_sh;
  bit     cur_valid;
  int     ne;
  int     m_slot, m_frame, m_vib;
  longint m_phase [NS];
  int     cfg_fnum, cfg_blk, cfg_mul;
  bit     cfg_pm;
  bit [NS-1:0] cfg_rst;
  vec_t   vecs [8];
  int     fadj_seq [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint model_delta(int f, int b, int m, bit pm, int v);
    int vt, m2v, fa;
    longint d;
    case (v)
      0, 4:    vt = 0;
      1, 3:    vt = 1;
      2:       vt = 2;
      5, 7:    vt = -1;
      default: vt = -2;
    endcase
    case (m)
      0:       m2v = 1;
      11:      m2v = 20;
      13:      m2v = 24;
      14, 15:  m2v = 30;
      default: m2v = 2 * m;
    endcase
    fa = f + (pm ? (f >> 6) * vt : 0);
    d  = (longint'(fa) << b) >> 1;
    return (d * m2v) >> 1;
  endfunction

  task automatic check_all();
    chk("slot", 64'(slot), 64'(m_slot));
    chk("frame_start", 64'(frame_start), 64'(m_slot == 0));
    chk("shift_amount", 64'(eg_shift), 64'(cur_sh));
    chk("phase_valid", 64'(valid), 64'(cur_valid));
    chk("out_slot", 64'(out_slot), 64'(cur_ph.slot));
    chk("phase_data", 64'(phdata), 64'(cur_ph.data));
  endtask

  task automatic drive_random();
    fnum  = 9'($urandom);
    blk   = 3'($urandom);
    mul   = 4'($urandom);
    pm_en = 1'($urandom);
    prst  = 1'($urandom);
  endtask

  task automatic tick(input bit en);
    exp_t   e;
    longint d;
    pcen_n = !en;
    if (en) begin
      fnum  = 9'(cfg_fnum);
      blk   = 3'(cfg_blk);
      mul   = 4'(cfg_mul);
      pm_en = cfg_pm;
      prst  = cfg_rst[m_slot];
      d = model_delta(cfg_fnum, cfg_blk, cfg_mul, cfg_pm, m_vib);
      if (cfg_rst[m_slot]) m_phase[m_slot] = 0;
      else m_phase[m_slot] = (m_phase[m_slot] + d) % 524288;
      e.due = ne + 2; e.slot = m_slot; e.data = int'(m_phase[m_slot] >> 9);
      q_ph.push_back(e);
      e.due = ne + 1; e.data = cfg_blk * 4 + ((cfg_fnum >> 7) & 3);
      q_sh.push_back(e);
      m_slot++;
      if (m_slot == NS) begin
        m_slot  = 0;
        m_frame = (m_frame + 1) % 2;
        if (m_frame == 0) m_vib = (m_vib + 1) % 8;
      end
    end else begin
      drive_random();
    end
    @(posedge clk); #1;
    if (en) begin
      ne++;
      while (q_sh.size() > 0 && q_sh[0].due == ne) begin
        e = q_sh.pop_front();
        cur_sh = e.data;
      end
      while (q_ph.size() > 0 && q_ph[0].due == ne) begin
        cur_ph    = q_ph.pop_front();
        cur_valid = 1'b1;
      end
    end
    check_all();
  endtask

  task automatic do_reset(input bit en);
    mrst   = 1'b1;
    pcen_n = !en;
    drive_random();
    @(posedge clk); #1;
    mrst = 1'b0;
    m_slot = 0; m_frame = 0; m_vib = 0; ne = 0;
    q_ph.delete(); q_sh.delete();
    cur_sh = 0; cur_valid = 1'b0;
    cur_ph.due = 0; cur_ph.slot = 0; cur_ph.data = 0;
    for (int i = 0; i < NS; i++) m_phase[i] = 0;
    check_all();
  endtask

  task automatic set_cfg(input int f, input int b, input int m, input bit pm);
    cfg_fnum = f; cfg_blk = b; cfg_mul = m; cfg_pm = pm; cfg_rst = '0;
  endtask

  // Advance until the output is tagged with slot s, then compare its phase word
  task automatic expect_out(input int s, input int exp, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b1);
      if (valid === 1'b1 && out_slot == 5'(s)) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL %s: no output for slot %0d within 40 enables", name, s);
    end else begin
      chk(name, 64'(phdata), 64'(exp));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    vecs[0] = '{256, 4, 1,  1, 4};
    vecs[1] = '{256, 4, 1,  2, 8};
    vecs[2] = '{256, 4, 1,  3, 12};
    vecs[3] = '{256, 4, 0,  1, 2};
    vecs[4] = '{256, 4, 10, 1, 40};
    vecs[5] = '{256, 4, 11, 1, 40};
    vecs[6] = '{511, 7, 15, 1, 958};
    vecs[7] = '{511, 7, 15, 2, 892};
    fadj_seq = '{448, 455, 462, 455, 448, 441, 434, 441};

    set_cfg(256, 4, 1, 1'b0);
    @(posedge clk); #1;
    do_reset(1'b0);

    // Frame-accumulation table
    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].fnum, vecs[v].blk, vecs[v].mul, 1'b0);
      do_reset(1'b1);
      for (int i = 0; i < NS * (vecs[v].nf - 1) + 2; i++) tick(1'b1);
      chk("vec_out_slot", 64'(out_slot), 64'd0);
      chk("vec_phase", 64'(phdata), 64'(vecs[v].exp));
      if (v == 0) begin
        for (int i = 0; i < 4; i++) tick(1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1);
      end
    end

    // Phase reset on slot 5 during frame 3
    set_cfg(256, 4, 1, 1'b0);
    do_reset(1'b1);
    for (int i = 0; i < 2 * NS; i++) tick(1'b1);
    cfg_rst[5] = 1'b1;
    expect_out(4, 12, "prst_neighbour");
    expect_out(5, 0, "prst_slot5");
    cfg_rst = '0;
    expect_out(5, 4, "prst_resume");
    expect_out(6, 16, "prst_other");

    // Vibrato sweep, vib step every two frames
    set_cfg(448, 4, 1, 1'b1);
    do_reset(1'b1);
    acc = 0;
    for (int f = 0; f < 16; f++) begin
      acc += 8 * fadj_seq[f / 2];
      expect_out(0, acc >> 9, "vib_frame");
    end

    // Reset mid-frame at slot 7 with enable active
    set_cfg(256, 4, 1, 1'b0);
    do_reset(1'b1);
    for (int i = 0; i < 40 && m_slot != 7; i++) tick(1'b1);
    chk("midreset_reached", 64'(slot), 64'd7);
    do_reset(1'b1);
    expect_out(0, 4, "midreset_restart0");
    expect_out(1, 4, "midreset_restart1");
    for (int i = 0; i < 3; i++) tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
